// File: rtl/key_debounce.sv
// Per-key two-flop synchroniser and run-length debouncer for push buttons.
// Produces clean active-high levels plus one-cycle press/release strobes.
module key_debounce #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] RAW_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] w_lvl;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  assign w_lvl = (ACTIVE_LOW != 0) ? ~r_s2 : r_s2;

  // A new level is accepted only after CNT_MAX+1 uninterrupted disagreeing cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1        <= RAW_IDLE;
      r_s2        <= RAW_IDLE;
      key         <= '0;
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1        <= key_raw;
      r_s2        <= r_s1;
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (w_lvl[i] == key[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          key[i]         <= w_lvl[i];
          key_press[i]   <= w_lvl[i];
          key_release[i] <= ~w_lvl[i];
          r_cnt[i]       <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with WIDTH=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key_raw;
  logic [1:0] key;
  logic [1:0] key_press;
  logic [1:0] key_release;

  int n_checks = 0;
  int n_errors = 0;

  key_debounce #(
    .WIDTH(2),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_raw(key_raw),
    .key(key),
    .key_press(key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] k, input logic [1:0] p,
                            input logic [1:0] r);
    check({tag, ".key"}, key, k);
    check({tag, ".press"}, key_press, p);
    check({tag, ".release"}, key_release, r);
  endtask

  // Drive raw before the edge, sample 1 time unit after it.
  task automatic step(input logic [1:0] raw, input logic [1:0] k, input logic [1:0] p,
                      input logic [1:0] r, input string tag);
    key_raw = raw;
    @(posedge clk);
    #1;
    check_outs(tag, k, p, r);
  endtask

  // Raw held from edge 0; key must change exactly at edge 5 with a single strobe.
  task automatic transition(input logic [1:0] raw, input logic [1:0] k_old,
                            input logic [1:0] k_new, input string tag);
    for (int i = 0; i < 8; i++) begin
      if (i < 5)
        step(raw, k_old, 2'b00, 2'b00, $sformatf("%s[%0d]", tag, i));
      else if (i == 5)
        step(raw, k_new, k_new & ~k_old, k_old & ~k_new, $sformatf("%s[%0d]", tag, i));
      else
        step(raw, k_new, 2'b00, 2'b00, $sformatf("%s[%0d]", tag, i));
    end
  endtask

  initial begin
    rst     = 1'b1;
    key_raw = 2'b11;
    #7;
    check_outs("in_reset", 2'b00, 2'b00, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) step(2'b11, 2'b00, 2'b00, 2'b00, $sformatf("idle[%0d]", i));

    transition(2'b10, 2'b00, 2'b01, "press");
    transition(2'b11, 2'b01, 2'b00, "release");

    step(2'b10, 2'b00, 2'b00, 2'b00, "bounce[0]");
    step(2'b10, 2'b00, 2'b00, 2'b00, "bounce[1]");
    step(2'b11, 2'b00, 2'b00, 2'b00, "bounce[2]");
    step(2'b10, 2'b00, 2'b00, 2'b00, "bounce[3]");
    step(2'b10, 2'b00, 2'b00, 2'b00, "bounce[4]");
    step(2'b10, 2'b00, 2'b00, 2'b00, "bounce[5]");
    for (int i = 6; i < 12; i++) step(2'b11, 2'b00, 2'b00, 2'b00, $sformatf("bounce[%0d]", i));
    transition(2'b10, 2'b00, 2'b01, "bounce_press");

    transition(2'b11, 2'b01, 2'b00, "release2");
    transition(2'b00, 2'b00, 2'b11, "both_press");
    transition(2'b11, 2'b11, 2'b00, "both_release");

    for (int i = 0; i < 5; i++) step(2'b10, 2'b00, 2'b00, 2'b00, $sformatf("pre_rst[%0d]", i));
    step(2'b10, 2'b01, 2'b01, 2'b00, "pre_rst[5]");
    rst = 1'b1;
    #1;
    check_outs("rst_async", 2'b00, 2'b00, 2'b00);
    @(posedge clk);
    #1;
    check_outs("rst_hold", 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    transition(2'b10, 2'b00, 2'b01, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input conditioning stage that sits directly upstream of the board-level combinational logic driven by the KEY buttons.
- Synchronises the raw, bouncing, asynchronous button pins into the clock domain and debounces each key independently.
- Outputs clean active-high key levels, which feed the combinational stage's key input.
- Also outputs one-cycle press and release strobes per key for downstream sequential logic.

Parameters:
- WIDTH, 2, number of keys handled; each key has its own independent channel.
- DEBOUNCE_CYCLES, 250000, number of consecutive cycles a new synchronised level must hold before it is accepted. Minimum 2.
- ACTIVE_LOW, 1, when 1 the raw pins read 0 while pressed and are inverted internally; when 0 they are used as-is.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- key_raw  input  WIDTH  raw button pins, asynchronous to clk, may bounce
- key  output  WIDTH  debounced level per key, 1 = pressed
- key_press  output  WIDTH  one-cycle strobe when key rises 0->1
- key_release  output  WIDTH  one-cycle strobe when key falls 1->0

Behaviour:
- Reset (asynchronous assert; logic is clocked from the first clk edge after deassert):
  - both synchroniser flops load the "not pressed" raw level (1 if ACTIVE_LOW, else 0);
  - key = 0, key_press = 0, key_release = 0;
  - all counters = 0.
- Synchroniser: two flops per key. s1 <= key_raw; s2 <= s1. Polarity is applied after s2: lvl = ACTIVE_LOW ? ~s2 : s2.
- Counter: width $clog2(DEBOUNCE_CYCLES), one per key, saturating never needed.
  - lvl == key: cnt <= 0.
  - lvl != key and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - lvl != key and cnt == DEBOUNCE_CYCLES-1: key <= lvl, cnt <= 0, and the matching strobe is registered high for exactly the next cycle.
- Strobes:
  - key_press and key_release are registered and asserted only in the cycle in which key has just changed.
  - They are never high simultaneously for the same key and never high two cycles in a row.
- Latency:
  - A raw pin change that settles before clk edge 0 and holds updates key at edge DEBOUNCE_CYCLES+1, i.e. 2 synchroniser cycles plus DEBOUNCE_CYCLES-1 count cycles.
  - The strobe is high from that same edge for one cycle.
- Glitch rejection: any excursion of lvl shorter than DEBOUNCE_CYCLES cycles clears the counter on return; key does not change and no strobe is produced.
- Bounce during a transition: each return of lvl to the current key value restarts the count from 0. Acceptance requires an uninterrupted run.
- Channels are fully independent. Simultaneous transitions on several keys produce simultaneous strobes on their respective bits.
- Reset mid-count or mid-strobe: everything returns to reset values immediately. A key held pressed through reset is re-detected as a fresh press, DEBOUNCE_CYCLES+1 edges after the first post-reset edge.
- No combinational path from key_raw to any output; all outputs are flop outputs.

Test Plan (WIDTH=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1):
1. Reset with key_raw=2'b11, release reset, hold 20 cycles -> key=2'b00 throughout; key_press and key_release never asserted.
2. Clean press: key_raw changes 2'b11->2'b10 before edge 0 and holds -> key[0] rises at edge 5; key_press=2'b01 for exactly one cycle; key[1] stays 0.
3. Bounce: key_raw[0] low for 2 cycles, high for 1 cycle, low for 3 cycles, then high again -> key stays 2'b00 and no strobes. Then hold key_raw[0] low for 6 cycles -> key[0]=1 with a single key_press[0] pulse.
4. Release: from key=2'b01, set key_raw=2'b11 and hold -> key[0] falls 5 edges later; key_release=2'b01 for one cycle; no key_press.
5. Simultaneous: key_raw 2'b11->2'b00 and hold -> key becomes 2'b11 on the same edge; key_press=2'b11 for one cycle.
6. Reset mid-operation: assert rst while key=2'b01 and a key_press pulse is high, keeping key_raw=2'b10 -> outputs clear immediately. After deassert, key[0] returns to 1 with a fresh key_press 5 edges after the first post-reset edge.
